// File: rtl/smg_scan_module.sv
// Two-digit 7-segment scan driver: time-multiplexes tens/ones patterns onto a shared bus
// with a blanking gap per slot. Define SMG_ZERO_BLANK_EN to blank a leading tens zero.
module smg_scan_module #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] Ten_SMG_Data,
    input  logic [7:0] One_SMG_Data,
    output logic [7:0] SMG_Data,
    output logic [1:0] Scan_Sig
);

    if (SCAN_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_param_check
        $error("smg_scan_module: need SCAN_DIV >= 2 and 0 <= BLANK_CYCLES < SCAN_DIV");
    end

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic             NO_BLANK   = (BLANK_CYCLES == 0);

    typedef enum logic [1:0] {
        BLANK_T = 2'd0,
        SHOW_T  = 2'd1,
        BLANK_O = 2'd2,
        SHOW_O  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       smg_d;
    logic [1:0]       scan_d;
    logic             slot_done;
    logic [7:0]       ten_pat;

    // Tens pattern as it should appear on the tube; a bare '0' (8'hc0) may be blanked.
    function automatic logic [7:0] tens_pattern(input logic [7:0] pat);
`ifdef SMG_ZERO_BLANK_EN
        return (pat == 8'hc0) ? 8'hff : pat;
`else
        return pat;
`endif
    endfunction

    assign ten_pat = tens_pattern(Ten_SMG_Data);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        smg_d     = SMG_Data;
        scan_d    = Scan_Sig;
        slot_done = 1'b0;

        // With no dead time the reset-time BLANK_T is left on the very first edge.
        unique case (state_q)
            BLANK_T, BLANK_O: slot_done = NO_BLANK || (cnt_q == BLANK_LAST);
            SHOW_T, SHOW_O:   slot_done = (cnt_q == SHOW_LAST);
        endcase

        if (slot_done) begin
            cnt_d = '0;
            unique case (state_q)
                BLANK_T: state_d = SHOW_T;
                SHOW_T:  state_d = NO_BLANK ? SHOW_O : BLANK_O;
                BLANK_O: state_d = SHOW_O;
                SHOW_O:  state_d = NO_BLANK ? SHOW_T : BLANK_T;
            endcase

            // Inputs are captured only here, so mid-slot changes never tear a digit.
            unique case (state_d)
                SHOW_T: begin
                    smg_d  = ten_pat;
                    scan_d = 2'b01;
                end
                SHOW_O: begin
                    smg_d  = One_SMG_Data;
                    scan_d = 2'b10;
                end
                BLANK_T, BLANK_O: begin
                    smg_d  = 8'hff;
                    scan_d = 2'b11;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= BLANK_T;
            cnt_q    <= '0;
            SMG_Data <= 8'hff;
            Scan_Sig <= 2'b11;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            SMG_Data <= smg_d;
            Scan_Sig <= scan_d;
        end
    end

endmodule

// File: tb/tb_smg_scan_module.sv
// Randomized bench for smg_scan_module: one instance with blanking, one without,
// both checked every cycle against a slot-timeline reference model.
module tb_smg_scan_module;

    localparam int SD = 10;
    localparam int BL = 2;

    logic       CLK    = 1'b0;
    logic       RST_N  = 1'b0;
    logic       clk_en = 1'b1;
    logic [7:0] ten    = 8'hf9;
    logic [7:0] one    = 8'ha4;
    logic [7:0] smg_a, smg_b;
    logic [1:0] scan_a, scan_b;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state per instance: edges since release, current slot, expected outputs
    int         tt[2];
    int         cur_slot[2];
    logic [7:0] exp_d[2];
    logic [1:0] exp_s[2];

    smg_scan_module #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .Ten_SMG_Data(ten), .One_SMG_Data(one),
        .SMG_Data(smg_a), .Scan_Sig(scan_a)
    );

    smg_scan_module #(.SCAN_DIV(SD), .BLANK_CYCLES(0)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .Ten_SMG_Data(ten), .One_SMG_Data(one),
        .SMG_Data(smg_b), .Scan_Sig(scan_b)
    );

    always #5 if (clk_en) CLK = ~CLK;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int blank_of(input int k);
        return (k == 0) ? BL : 0;
    endfunction

    // Slot shown after t edges since release: 0=reset, 1=blank tens, 2=tens,
    // 3=blank ones, 4=ones. Without blanking the sequence starts one edge late.
    function automatic int slot_of(input int t, input int b);
        int off, ph;
        off = (b == 0) ? 1 : 0;
        if (t < off) return 0;
        ph = (t - off) % (2 * SD);
        if (ph < b)      return 1;
        if (ph < SD)     return 2;
        if (ph < SD + b) return 3;
        return 4;
    endfunction

    function automatic logic [7:0] exp_tens(input logic [7:0] pat);
`ifdef SMG_ZERO_BLANK_EN
        if (pat == 8'hc0) return 8'hff;
`endif
        return pat;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            tt[k]       = 0;
            cur_slot[k] = slot_of(0, blank_of(k));
            exp_d[k]    = 8'hff;
            exp_s[k]    = 2'b11;
        end
    endtask

    task automatic model_edge(input int k);
        int s;
        tt[k]++;
        s = slot_of(tt[k], blank_of(k));
        if (s != cur_slot[k]) begin
            case (s)
                2: begin exp_d[k] = exp_tens(ten); exp_s[k] = 2'b01; end
                4: begin exp_d[k] = one;           exp_s[k] = 2'b10; end
                default: begin exp_d[k] = 8'hff;   exp_s[k] = 2'b11; end
            endcase
            cur_slot[k] = s;
        end
    endtask

    task automatic check_all();
        check_val("blank_data", smg_a, exp_d[0]);
        check_val("blank_scan", {6'd0, scan_a}, {6'd0, exp_s[0]});
        check_val("noblank_data", smg_b, exp_d[1]);
        check_val("noblank_scan", {6'd0, scan_b}, {6'd0, exp_s[1]});
    endtask

    function automatic logic [7:0] pick_pattern();
        case ($urandom_range(4))
            0: return 8'hf9;
            1: return 8'ha4;
            2: return 8'hb0;
            3: return 8'hc0;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic drive_random();
        if ($urandom_range(2) == 0) ten = pick_pattern();
        if ($urandom_range(2) == 0) one = pick_pattern();
    endtask

    task automatic step(input bit rnd);
        @(posedge CLK);
        if (RST_N) for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        check_all();
        @(negedge CLK);
        if (rnd) drive_random();
    endtask

    initial begin
        bit reached;
        model_reset();

        // Held in reset while inputs toggle
        repeat (6) step(1'b1);

        ten   = 8'hf9;
        one   = 8'ha4;
        RST_N = 1'b1;
        repeat (45) step(1'b0);

        // Random patterns, including mid-slot changes and the zero pattern
        repeat (150) step(1'b1);

        // Advance into the ones slot of the blanked instance, then stop the clock
        reached = 1'b0;
        for (int i = 0; i < 3 * SD && !reached; i++) begin
            step(1'b1);
            if (cur_slot[0] == 4 && (tt[0] % (2 * SD)) >= SD + BL + 3) reached = 1'b1;
        end
        check_val("reach_show_o", {7'd0, reached}, 8'd1);

        #1;
        clk_en = 1'b0;
        RST_N  = 1'b0;
        model_reset();
        #1;
        check_all();
        ten = 8'h12;
        one = 8'h34;
        #20;
        check_all();

        ten = 8'hf9;
        one = 8'ha4;
        #3;
        RST_N = 1'b1;
        #4;
        clk_en = 1'b1;
        repeat (45) step(1'b0);
        repeat (100) step(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
